// File: rtl/cheshire_irq_gateway_pkg.sv
// Shared types and helpers for the Cheshire interrupt gateway: gateway state
// encoding, ID width derivation and the lowest-index priority encoder.
package cheshire_irq_gateway_pkg;

  typedef enum logic [1:0] {
    GW_IDLE = 2'd0,
    GW_PEND = 2'd1,
    GW_SERV = 2'd2
  } gw_state_e;

  // Upper bound on the source count accepted by the priority encoder.
  localparam int unsigned MaxSrc = 32'd1024;

  function automatic int unsigned iomsb(input int unsigned width);
    return (width > 32'd0) ? (width - 32'd1) : 32'd0;
  endfunction

  function automatic int unsigned id_width(input int unsigned num_src);
    int unsigned bits;
    bits = unsigned'($clog2(num_src));
    return (num_src > 32'd1) ? (iomsb(bits) + 32'd1) : 32'd1;
  endfunction

  // Lowest set index at or above 1 wins; 0 means nothing is set.
  function automatic int unsigned prio_enc(input logic [MaxSrc-1:0] vec);
    int unsigned idx;
    idx = 32'd0;
    for (int i = int'(MaxSrc) - 1; i >= 1; i--) begin
      if (vec[i]) begin
        idx = unsigned'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/cheshire_irq_gateway_src.sv
// Per-source gateway: input synchroniser, rising-edge detector, saturating
// pending-edge counter and the IDLE/PEND/SERV handshake state.
module cheshire_irq_gateway_src
  import cheshire_irq_gateway_pkg::*;
#(
  parameter int unsigned NumSyncStages = 2,
  parameter int unsigned EdgeCntWidth  = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      intr_i,
  input  logic      edge_mode_i,
  input  logic      claim_i,
  input  logic      cmpl_i,
  output gw_state_e state_o
);

  localparam logic [EdgeCntWidth-1:0] CntMax = {EdgeCntWidth{1'b1}};
  localparam logic [EdgeCntWidth-1:0] CntOne = EdgeCntWidth'(32'd1);

  logic                    synced_s;
  logic                    edge_s;
  logic                    take_s;
  logic                    prev_q, prev_d;
  logic [EdgeCntWidth-1:0] cnt_q, cnt_d;
  gw_state_e               state_q, state_d;

  if (NumSyncStages == 0) begin : g_nosync
    assign synced_s = intr_i;
  end else begin : g_sync
    logic [NumSyncStages-1:0] sync_q, sync_d;
    logic [NumSyncStages:0]   chain_s;

    assign chain_s  = {sync_q, intr_i};
    assign synced_s = sync_q[NumSyncStages-1];

    always_comb begin
      sync_d = chain_s[NumSyncStages-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= '0;
      end else begin
        sync_q <= sync_d;
      end
    end
  end

  always_comb begin
    prev_d  = synced_s;
    edge_s  = edge_mode_i & synced_s & ~prev_q;
    state_d = state_q;
    take_s  = 1'b0;
    case (state_q)
      GW_IDLE: begin
        // Edge sources drain one counted edge per delivery.
        if (edge_mode_i ? (cnt_q != '0) : synced_s) begin
          state_d = GW_PEND;
          take_s  = edge_mode_i;
        end else begin
          state_d = GW_IDLE;
        end
      end
      GW_PEND: begin
        if (claim_i) begin
          state_d = GW_SERV;
        end else begin
          state_d = GW_PEND;
        end
      end
      GW_SERV: begin
        if (cmpl_i) begin
          state_d = GW_IDLE;
        end else begin
          state_d = GW_SERV;
        end
      end
      default: begin
        state_d = GW_IDLE;
      end
    endcase

    if (!edge_mode_i) begin
      cnt_d = '0;
    end else if (edge_s && !take_s) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : (cnt_q + CntOne);
    end else if (!edge_s && take_s) begin
      cnt_d = cnt_q - CntOne;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= GW_IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/cheshire_irq_gateway.sv
// Interrupt gateway top: one gateway per source, per-target lowest-ID
// arbitration, claim resolution across targets and completion decode.
module cheshire_irq_gateway
  import cheshire_irq_gateway_pkg::*;
#(
  parameter int unsigned NumSrc        = 32,
  parameter int unsigned NumTgt        = 2,
  parameter int unsigned NumSyncStages = 2,
  parameter int unsigned EdgeCntWidth  = 4,
  parameter int unsigned IdWidth       = id_width(NumSrc)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [iomsb(NumSrc):0]            intr_i,
  input  logic [iomsb(NumSrc):0]            edge_mode_i,
  input  logic [iomsb(NumSrc):0]            enable_i,
  input  logic [NumTgt-1:0][NumSrc-1:0]     route_i,
  output logic [NumTgt-1:0]                 irq_o,
  output logic [NumTgt-1:0][IdWidth-1:0]    claim_id_o,
  input  logic [NumTgt-1:0]                 claim_i,
  output logic [NumTgt-1:0]                 claim_ack_o,
  input  logic                              cmpl_valid_i,
  input  logic [IdWidth-1:0]                cmpl_id_i
);

  gw_state_e                       state_s [NumSrc];
  logic [NumSrc-1:0]               pend_s;
  logic [NumSrc-1:0]               taken_s;
  logic [NumSrc-1:0]               cmpl_src_s;
  logic [MaxSrc-1:0]               elig_ext_s;
  logic [NumTgt-1:0][IdWidth-1:0]  claim_id_s;
  logic [NumTgt-1:0]               ack_s;
  logic [NumTgt-1:0]               irq_q, irq_d;
  logic                            unused_s;

  assign state_s[0] = GW_IDLE;

  for (genvar s = 1; s < NumSrc; s++) begin : g_src
    cheshire_irq_gateway_src #(
      .NumSyncStages (NumSyncStages),
      .EdgeCntWidth  (EdgeCntWidth)
    ) i_src (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .intr_i      (intr_i[s]),
      .edge_mode_i (edge_mode_i[s]),
      .claim_i     (taken_s[s]),
      .cmpl_i      (cmpl_src_s[s]),
      .state_o     (state_s[s])
    );
  end

  always_comb begin
    pend_s     = '0;
    cmpl_src_s = '0;
    for (int unsigned s = 1; s < NumSrc; s++) begin
      pend_s[s]     = (state_s[s] == GW_PEND);
      cmpl_src_s[s] = cmpl_valid_i && (cmpl_id_i == IdWidth'(s));
    end
  end

  // Lower targets get first pick when several claim the same source.
  always_comb begin
    elig_ext_s = '0;
    taken_s    = '0;
    claim_id_s = '0;
    ack_s      = '0;
    irq_d      = '0;
    for (int unsigned t = 0; t < NumTgt; t++) begin
      elig_ext_s               = '0;
      elig_ext_s[NumSrc-1:0]   = pend_s & enable_i & route_i[t];
      claim_id_s[t]            = IdWidth'(prio_enc(elig_ext_s));
      irq_d[t]                 = (claim_id_s[t] != '0);
      if (claim_i[t] && (claim_id_s[t] != '0) && !taken_s[claim_id_s[t]]) begin
        ack_s[t]                 = 1'b1;
        taken_s[claim_id_s[t]]   = 1'b1;
      end else begin
        ack_s[t]                 = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o       = irq_q;
  assign claim_id_o  = claim_id_s;
  assign claim_ack_o = ack_s;

  // Source 0 is reserved; its input bits are intentionally dropped.
  assign unused_s = ^{intr_i[0], edge_mode_i[0], taken_s[0], cmpl_src_s[0]};

endmodule

// File: tb/tb_cheshire_irq_gateway.sv
// Self-checking bench for cheshire_irq_gateway: table vectors, directed
// corner sequences and a randomized phase against a behavioural model.
module tb_cheshire_irq_gateway;

  localparam int NS   = 32;
  localparam int NT   = 2;
  localparam int SS   = 2;
  localparam int CMAX = 15;
  localparam int M_IDLE = 0;
  localparam int M_PEND = 1;
  localparam int M_SERV = 2;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic [NS-1:0]        intr_i, edge_mode_i, enable_i;
  logic [NT-1:0][NS-1:0] route_i;
  logic [NT-1:0]        irq_o;
  logic [NT-1:0][4:0]   claim_id_o;
  logic [NT-1:0]        claim_i, claim_ack_o;
  logic                 cmpl_valid_i;
  logic [4:0]           cmpl_id_i;

  int n_err = 0;
  int n_chk = 0;

  cheshire_irq_gateway dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .intr_i       (intr_i),
    .edge_mode_i  (edge_mode_i),
    .enable_i     (enable_i),
    .route_i      (route_i),
    .irq_o        (irq_o),
    .claim_id_o   (claim_id_o),
    .claim_i      (claim_i),
    .claim_ack_o  (claim_ack_o),
    .cmpl_valid_i (cmpl_valid_i),
    .cmpl_id_i    (cmpl_id_i)
  );

  always #5 clk = ~clk;

  // Behavioural model: the line seen by a gateway is the raw line SS cycles ago.
  int            m_state [NS];
  int            m_cnt   [NS];
  logic [NS-1:0] m_hist  [SS+1];
  logic [NT-1:0] m_irq;
  logic [4:0]    e_id    [NT];
  logic [NT-1:0] e_ack;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_state[s] = M_IDLE;
      m_cnt[s]   = 0;
    end
    for (int k = 0; k <= SS; k++) m_hist[k] = '0;
    m_irq = '0;
  endtask

  task automatic model_eval();
    logic [NS-1:0] taken;
    taken = '0;
    for (int t = 0; t < NT; t++) begin
      e_id[t] = 5'd0;
      for (int s = NS - 1; s >= 1; s--)
        if (m_state[s] == M_PEND && enable_i[s] && route_i[t][s]) e_id[t] = 5'(s);
      e_ack[t] = claim_i[t] && (e_id[t] != 5'd0) && !taken[e_id[t]];
      if (e_ack[t]) taken[e_id[t]] = 1'b1;
    end
  endtask

  task automatic model_step();
    bit synced, edg, claimed;
    int dec, nc;
    model_eval();
    for (int s = 1; s < NS; s++) begin
      synced  = m_hist[SS-1][s];
      edg     = edge_mode_i[s] && synced && !m_hist[SS][s];
      claimed = 1'b0;
      for (int t = 0; t < NT; t++) if (e_ack[t] && e_id[t] == 5'(s)) claimed = 1'b1;
      dec = 0;
      if (m_state[s] == M_IDLE) begin
        if (edge_mode_i[s] ? (m_cnt[s] > 0) : synced) begin
          m_state[s] = M_PEND;
          dec = edge_mode_i[s] ? 1 : 0;
        end
      end else if (m_state[s] == M_PEND) begin
        if (claimed) m_state[s] = M_SERV;
      end else begin
        if (cmpl_valid_i && cmpl_id_i == 5'(s)) m_state[s] = M_IDLE;
      end
      nc = m_cnt[s] + (edg ? 1 : 0) - dec;
      m_cnt[s] = !edge_mode_i[s] ? 0 : ((nc > CMAX) ? CMAX : nc);
    end
    for (int t = 0; t < NT; t++) m_irq[t] = (e_id[t] != 5'd0);
    for (int k = SS; k >= 1; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = intr_i;
  endtask

  task automatic tick();
    @(negedge clk);
    model_eval();
    chk("irq", 64'(irq_o), 64'(m_irq));
    chk("claim_id", 64'({claim_id_o[1], claim_id_o[0]}), 64'({e_id[1], e_id[0]}));
    chk("claim_ack", 64'(claim_ack_o), 64'(e_ack));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    intr_i = '0; edge_mode_i = '0; enable_i = '1; route_i = '0;
    claim_i = '0; cmpl_valid_i = 1'b0; cmpl_id_i = 5'd0;
  endtask

  task automatic wait_id(input int t, input logic [4:0] id, input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (claim_id_o[t] == id) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic pulse3(input int n);
    for (int i = 0; i < n; i++) begin
      intr_i[3] = 1'b1; tick();
      intr_i[3] = 1'b0; tick();
    end
    repeat (4) tick();
  endtask

  // Completes source 3 and re-claims it for as long as it keeps re-pending.
  task automatic serve_loop(output int n);
    bit found;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cmpl_valid_i = 1'b1; cmpl_id_i = 5'd3; tick();
      cmpl_valid_i = 1'b0;
      wait_id(0, 5'd3, 6, found);
      if (!found) break;
      claim_i = 2'b01; tick(); claim_i = 2'b00;
      n++;
    end
  endtask

  typedef struct {
    logic       intr5;
    logic [1:0] claim;
    logic       cv;
    logic [4:0] cid;
    logic [1:0] irq;
    logic [4:0] id0;
    logic [1:0] ack;
  } row_t;

  row_t tbl [14];

  initial begin
    bit found;
    int n, st, pick;

    tbl[0]  = '{1'b1, 2'b00, 1'b0, 5'd0, 2'b00, 5'd0, 2'b00};
    tbl[1]  = '{1'b1, 2'b00, 1'b0, 5'd0, 2'b00, 5'd0, 2'b00};
    tbl[2]  = '{1'b1, 2'b00, 1'b0, 5'd0, 2'b00, 5'd0, 2'b00};
    tbl[3]  = '{1'b1, 2'b00, 1'b0, 5'd0, 2'b00, 5'd5, 2'b00};
    tbl[4]  = '{1'b1, 2'b00, 1'b0, 5'd0, 2'b01, 5'd5, 2'b00};
    tbl[5]  = '{1'b1, 2'b01, 1'b0, 5'd0, 2'b01, 5'd5, 2'b01};
    tbl[6]  = '{1'b1, 2'b00, 1'b0, 5'd0, 2'b01, 5'd0, 2'b00};
    tbl[7]  = '{1'b1, 2'b00, 1'b1, 5'd5, 2'b00, 5'd0, 2'b00};
    tbl[8]  = '{1'b1, 2'b00, 1'b0, 5'd0, 2'b00, 5'd0, 2'b00};
    tbl[9]  = '{1'b1, 2'b00, 1'b0, 5'd0, 2'b00, 5'd5, 2'b00};
    tbl[10] = '{1'b0, 2'b01, 1'b0, 5'd0, 2'b01, 5'd5, 2'b01};
    tbl[11] = '{1'b0, 2'b00, 1'b1, 5'd5, 2'b01, 5'd0, 2'b00};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 5'd0, 2'b00, 5'd0, 2'b00};
    tbl[13] = '{1'b0, 2'b00, 1'b0, 5'd0, 2'b00, 5'd0, 2'b00};

    clear_inputs();
    claim_i = 2'b11;
    rst_ni  = 1'b0;
    model_reset();
    #3;
    chk("reset_irq", 64'(irq_o), 64'd0);
    chk("reset_claim_id", 64'({claim_id_o[1], claim_id_o[0]}), 64'd0);
    chk("reset_ack", 64'(claim_ack_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    claim_i = 2'b00;
    rst_ni  = 1'b1;

    // Level source 5 on target 0: deliver, claim, complete with line high.
    route_i[0] = 32'h0000_0020;
    for (int i = 0; i < 14; i++) begin
      intr_i[5] = tbl[i].intr5; claim_i = tbl[i].claim;
      cmpl_valid_i = tbl[i].cv; cmpl_id_i = tbl[i].cid;
      #2;
      chk($sformatf("tbl%0d_irq", i), 64'(irq_o), 64'(tbl[i].irq));
      chk($sformatf("tbl%0d_id0", i), 64'(claim_id_o[0]), 64'(tbl[i].id0));
      chk($sformatf("tbl%0d_ack", i), 64'(claim_ack_o), 64'(tbl[i].ack));
      tick();
    end

    // Edge source 3: counted re-delivery and saturation.
    clear_inputs();
    edge_mode_i[3] = 1'b1; route_i[0] = 32'h0000_0008;
    pulse3(1);
    wait_id(0, 5'd3, 10, found);
    chk("edge_first_delivery", 64'(found), 64'd1);
    claim_i = 2'b01; tick(); claim_i = 2'b00;
    pulse3(3);
    serve_loop(n);
    chk("edge_3_deliveries", 64'(n), 64'd3);
    repeat (3) tick();
    chk("edge_drained_irq", 64'(irq_o[0]), 64'd0);
    pulse3(1);
    wait_id(0, 5'd3, 10, found);
    chk("edge_sat_first", 64'(found), 64'd1);
    claim_i = 2'b01; tick(); claim_i = 2'b00;
    pulse3(20);
    serve_loop(n);
    chk("edge_sat_deliveries", 64'(n), 64'd15);

    // Priority on target 1: 2 before 7.
    clear_inputs();
    route_i[1] = 32'h0000_0084; intr_i[2] = 1'b1; intr_i[7] = 1'b1;
    repeat (4) tick();
    chk("prio_first", 64'(claim_id_o[1]), 64'd2);
    claim_i = 2'b10; tick(); claim_i = 2'b00;
    chk("prio_second", 64'(claim_id_o[1]), 64'd7);
    claim_i = 2'b10; tick(); claim_i = 2'b00;
    intr_i[2] = 1'b0; intr_i[7] = 1'b0;
    repeat (3) tick();
    cmpl_valid_i = 1'b1; cmpl_id_i = 5'd2; tick();
    cmpl_id_i = 5'd7; tick();
    cmpl_valid_i = 1'b0;

    // Source 4 on both targets, simultaneous claim.
    route_i[0] = 32'h0000_0010; route_i[1] = 32'h0000_0010; intr_i[4] = 1'b1;
    repeat (4) tick();
    claim_i = 2'b11;
    #1;
    chk("dual_claim_ack", 64'(claim_ack_o), 64'd1);
    tick(); claim_i = 2'b00;
    chk("dual_claim_t1_id", 64'(claim_id_o[1]), 64'd0);
    chk("dual_claim_t0_id", 64'(claim_id_o[0]), 64'd0);

    // Spurious completions leave source 4 in service; source 0 never fires.
    cmpl_valid_i = 1'b1;
    cmpl_id_i = 5'd0; tick();
    cmpl_id_i = 5'(40); tick();
    cmpl_id_i = 5'd6; tick();
    cmpl_valid_i = 1'b0;
    repeat (3) tick();
    chk("spurious_cmpl_id0", 64'(claim_id_o[0]), 64'd0);
    route_i[0] = '1; route_i[1] = '1; intr_i[0] = 1'b1;
    repeat (6) tick();
    chk("src0_no_irq", 64'(irq_o), 64'd0);

    // Asynchronous reset with PEND/SERV sources and a non-zero count.
    intr_i[0] = 1'b0; route_i[1] = '0; route_i[0] = 32'h0000_0018;
    edge_mode_i[3] = 1'b1;
    intr_i[3] = 1'b1; tick(); intr_i[3] = 1'b0; tick();
    intr_i[3] = 1'b1; tick(); intr_i[3] = 1'b0; tick();
    repeat (3) tick();
    chk("pre_reset_irq", 64'(irq_o[0]), 64'd1);
    claim_i = 2'b11;
    rst_ni  = 1'b0;
    #1;
    chk("mid_reset_irq", 64'(irq_o), 64'd0);
    chk("mid_reset_claim_id", 64'({claim_id_o[1], claim_id_o[0]}), 64'd0);
    chk("mid_reset_ack", 64'(claim_ack_o), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    claim_i = 2'b00;
    rst_ni  = 1'b1;
    tick();
    chk("post_reset_quiet", 64'(claim_id_o[0]), 64'd0);
    repeat (4) tick();
    chk("post_reset_level_repend", 64'(claim_id_o[0]), 64'd4);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin
        edge_mode_i = $urandom();
        enable_i    = $urandom() | $urandom();
        route_i[0]  = $urandom();
        route_i[1]  = $urandom();
      end
      intr_i       = intr_i ^ ($urandom() & $urandom() & $urandom());
      claim_i      = 2'($urandom_range(0, 3));
      cmpl_valid_i = 1'($urandom_range(0, 1));
      st   = int'($urandom_range(0, 31));
      pick = st;
      for (int k = 31; k >= 0; k--)
        if (m_state[(st + k) % 32] == M_SERV) pick = (st + k) % 32;
      cmpl_id_i = 5'(pick);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cheshire_irq_gateway.md
Name: cheshire_irq_gateway

Overview:
- Parametrised interrupt gateway that collects the SoC interrupt vector (internal peripheral lines plus external lines) and presents per-hart interrupt requests.
- Generalises the fixed interrupt map: arbitrary source and target counts, a per-source level/edge mode, and counted edge coalescing.
- Supports claim/complete handshakes per target.
- Sits between the peripheral interrupt wires and the hart interrupt inputs (CLINT/PLIC side).

Parameters:
- NumSrc, 32, number of sources; source 0 is reserved and hardwired to zero.
- NumTgt, 2, number of interrupt targets (harts/contexts).
- NumSyncStages, 2, synchroniser depth on asynchronous sources; 0 means no synchroniser.
- EdgeCntWidth, 4, width of the saturating pending-edge counter per source.
- IdWidth, $clog2(NumSrc), width of source IDs (derived).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- intr_i  in  NumSrc  raw interrupt lines; bit 0 is ignored
- edge_mode_i  in  NumSrc  1 = rising-edge source, 0 = level source (quasi-static)
- enable_i  in  NumSrc  per-source enable
- route_i  in  NumTgt x NumSrc  route_i[t][s] = 1 means source s may be delivered to target t
- irq_o  out  NumTgt  per-target interrupt request
- claim_id_o  out  NumTgt x IdWidth  highest-priority claimable source per target; 0 = none
- claim_i  in  NumTgt  claim strobe per target
- claim_ack_o  out  NumTgt  claim accepted this cycle
- cmpl_valid_i  in  1  completion strobe
- cmpl_id_i  in  IdWidth  ID of the completed source

Behaviour:
- Sync: intr_i passes through NumSyncStages flops (reset 0). In edge mode, a rising edge is detected against a delayed copy (reset 0). Request latency from intr_i to state change is NumSyncStages+1 cycles.
- Per-source gateway FSM, reset IDLE:
  - IDLE -> PEND: level source with synced line = 1, or edge source with cnt > 0 (cnt decrements on this transition).
  - PEND -> SERV: on an accepted claim.
  - SERV -> IDLE: on cmpl_valid_i with cmpl_id_i == s.
- Edge counter: saturating at 2^EdgeCntWidth-1 and never wraps.
  - Increments on every detected edge, in any state.
  - If an increment and a decrement fall in the same cycle, the count is unchanged.
- Level source: asserting the line while in PEND or SERV has no extra effect. If the line is still high when the source returns to IDLE, it re-pends on the next cycle.
- Eligibility: eligible[t][s] = (state==PEND) & enable_i[s] & route_i[t][s].
  - claim_id_o[t] = lowest eligible s (lower ID = higher priority); 0 if none. Combinational from state.
  - irq_o[t] = (claim_id_o[t] != 0), registered (one-cycle latency); reset 0.
- Claim: claim_i[t] with claim_id_o[t] != 0 moves that source to SERV.
  - If several targets claim the same source in one cycle, the lowest t wins. The others get claim_ack_o = 0 and no state change.
  - A claim with claim_id_o = 0 is a no-op with ack 0.
  - claim_ack_o is combinational and reset-inactive.
- Complete: ignored for cmpl_id_i = 0, for IDs ≥ NumSrc, and for sources not in SERV.
  - A completion and a new edge in the same cycle: the source goes to IDLE and cnt increments. It re-pends next cycle.
  - A claim and a completion of the same ID in the same cycle cannot occur because PEND ≠ SERV. Nothing further is required.
- Disabling: clearing enable_i hides a PEND source but keeps its state and count. A source already in SERV completes normally.
- Mode change while not IDLE: takes effect on the next IDLE evaluation. The counter is cleared when edge_mode_i = 0.
- Reset mid-operation: all states return to IDLE, counters and sync flops to 0, irq_o to 0, immediately (asynchronous).

Decomposition:
- Shared package entries:
  - gw_state_e enum (IDLE/PEND/SERV).
  - A priority-encode function.
  - The IdWidth derivation helper, reusing the existing iomsb-style width helper.
- Natural sub-module: cheshire_irq_gateway_src, one instance per source, containing the synchroniser, edge detector, counter and FSM. The top level holds the per-target arbitration and claim resolution.

Test Plan:
- Level source 5 routed to target 0, intr_i[5] high: irq_o[0]=1 and claim_id_o[0]=5 after NumSyncStages+2 cycles. Claim: ack=1, irq_o[0] drops the next cycle. Complete ID 5 with the line still high: source re-pends and irq_o[0] rises again.
- Edge source 3, 3 pulses while in SERV: cnt=3. Each of 3 complete/claim cycles re-delivers ID 3, then irq stays 0. With 20 pulses and EdgeCntWidth=4, exactly 15 deliveries follow.
- Sources 7 and 2 both pending on target 1: claim_id_o[1]=2 first. After claiming 2, claim_id_o[1]=7.
- Source 4 routed to both targets, claim_i=2'b11 in the same cycle: claim_ack_o=2'b01, source is in SERV, and target 1 sees claim_id_o=0.
- Spurious completions (ID 0, ID 40, ID 6 in IDLE) cause no state change. Driving intr_i[0]=1 never raises irq_o.
- rst_ni pulled low with sources in PEND/SERV and cnt>0: all outputs are 0 immediately. After release, no interrupt appears without a new input event (a level line still high re-pends after the sync latency).
